// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types and constants for the RV32I pipeline front end.
//                - NOP_INST    : addi x0,x0,0, used as the pipeline bubble
//                - ctr_t       : 2-bit saturating branch-direction counter
//                - ifid_t      : contents of the IF/ID pipeline register
//                - ctr_update  : saturating counter step toward the outcome
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        hit;
        logic        pred_taken;
        logic [31:0] pred_target;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{
        pc          : 32'h0000_0000,
        inst        : NOP_INST,
        hit         : 1'b0,
        pred_taken  : 1'b0,
        pred_target : 32'h0000_0000
    };

    // Move the counter one step toward the observed outcome, saturating.
    function automatic ctr_t ctr_update(input ctr_t c, input logic taken);
        ctr_t n;
        n = c;
        case (c)
            SNT:     n = taken ? WNT : SNT;
            WNT:     n = taken ? WT  : SNT;
            WT:      n = taken ? ST  : WNT;
            default: n = taken ? ST  : WT;
        endcase
        return n;
    endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/btb_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : btb_predictor
//  Description : Direct-mapped branch target buffer with 2-bit counters.
//                Lookup is combinational; updates are written at the clock
//                edge, so a same-cycle lookup of the updated index sees the
//                old contents.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                lookup_word [29:0]  - fetch PC[31:2]
//                hit/pred_taken      - lookup results
//                pred_target [31:0]  - stored target of the indexed entry
//                upd_valid           - resolved branch present this cycle
//                upd_word [29:0]     - resolved branch PC[31:2]
//                upd_taken           - actual outcome
//                upd_target [31:0]   - actual taken target
//  Revision    : 1.0 - initial release
// ============================================================================
module btb_predictor
    import pipe_pkg::*;
#(
    parameter int BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] lookup_word,
    output logic        hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [29:0] upd_word,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        ctr_t             ctr;
    } btb_entry_t;

    localparam btb_entry_t C_ENTRY_RESET = '{
        valid  : 1'b0,
        tag    : '0,
        target : 32'h0000_0000,
        ctr    : WNT
    };

    btb_entry_t       r_entry [BTB_ENTRIES];

    logic [IDX-1:0]   w_lidx;
    logic [TAG_W-1:0] w_ltag;
    btb_entry_t       w_lent;
    logic [IDX-1:0]   w_uidx;
    logic [TAG_W-1:0] w_utag;
    btb_entry_t       w_uent;
    logic             w_uhit;
    btb_entry_t       w_uent_next;

    // Lookup port
    assign w_lidx      = lookup_word[IDX-1:0];
    assign w_ltag      = lookup_word[29:IDX];
    assign w_lent      = r_entry[w_lidx];
    assign hit         = w_lent.valid && (w_lent.tag == w_ltag);
    assign pred_taken  = hit && w_lent.ctr[1];
    assign pred_target = w_lent.target;

    // Update port
    assign w_uidx = upd_word[IDX-1:0];
    assign w_utag = upd_word[29:IDX];
    assign w_uent = r_entry[w_uidx];
    assign w_uhit = w_uent.valid && (w_uent.tag == w_utag);

    always_comb begin
        w_uent_next = w_uent;
        if (upd_taken) begin
            if (!w_uhit) begin
                // Allocate (or replace an aliasing entry) as weakly taken.
                w_uent_next.valid  = 1'b1;
                w_uent_next.tag    = w_utag;
                w_uent_next.target = upd_target;
                w_uent_next.ctr    = WT;
            end else begin
                w_uent_next.target = upd_target;
                w_uent_next.ctr    = ctr_update(w_uent.ctr, 1'b1);
            end
        end else if (w_uhit) begin
            w_uent_next.ctr = ctr_update(w_uent.ctr, 1'b0);
        end
        // Not-taken on a miss leaves the entry untouched (default above).
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_entry[i] <= C_ENTRY_RESET;
            end
        end else if (upd_valid) begin
            r_entry[w_uidx] <= w_uent_next;
        end
    end

endmodule : btb_predictor
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : RV32I instruction-fetch stage. Holds the PC, predicts via
//                the BTB, resolves mispredicts reported by EX and drives the
//                IF/ID pipeline register.
//  Ports       : clk, rst               - clock, synchronous active-high reset
//                stall                  - freeze PC and IF/ID
//                imem_addr / imem_rdata - instruction memory (comb. read)
//                br_*                   - branch resolution from EX
//                flush                  - mispredict, kills IF/ID and ID/EX
//                if_*                   - IF/ID register outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module if_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        br_valid,
    input  logic [31:0] br_pc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        br_pred_taken,
    input  logic [31:0] br_pred_target,
    output logic        flush,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_hit,
    output logic        if_pred_taken,
    output logic [31:0] if_pred_target
);

    logic [31:0] r_pc;
    ifid_t       r_ifid;

    logic        w_hit;
    logic        w_pred_taken;
    logic [31:0] w_pred_target;
    logic        w_mispredict;
    logic [31:0] w_next_pc;

    btb_predictor #(
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .lookup_word (r_pc[31:2]),
        .hit         (w_hit),
        .pred_taken  (w_pred_taken),
        .pred_target (w_pred_target),
        .upd_valid   (br_valid),
        .upd_word    (br_pc[31:2]),
        .upd_taken   (br_taken),
        .upd_target  (br_target)
    );

    // A taken branch whose direction was right but target wrong (e.g. a
    // stale BTB target) is still a mispredict.
    assign w_mispredict = br_valid &&
                          ((br_taken != br_pred_taken) ||
                           (br_taken && (br_target != br_pred_target)));
    assign flush = w_mispredict;

    // Mispredict redirect overrides stall: the stalled instructions are on
    // the wrong path and are being killed anyway.
    always_comb begin
        w_next_pc = r_pc + 32'd4;
        if (w_mispredict) begin
            w_next_pc = br_taken ? br_target : (br_pc + 32'd4);
        end else if (stall) begin
            w_next_pc = r_pc;
        end else if (w_pred_taken) begin
            w_next_pc = w_pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ifid <= IFID_BUBBLE;
        end else if (w_mispredict) begin
            r_ifid <= IFID_BUBBLE;
        end else if (!stall) begin
            r_ifid.pc          <= r_pc;
            r_ifid.inst        <= imem_rdata;
            r_ifid.hit         <= w_hit;
            r_ifid.pred_taken  <= w_pred_taken;
            r_ifid.pred_target <= w_pred_target;
        end
    end

    assign imem_addr      = r_pc;
    assign if_pc          = r_ifid.pc;
    assign if_inst        = r_ifid.inst;
    assign if_hit         = r_ifid.hit;
    assign if_pred_taken  = r_ifid.pred_taken;
    assign if_pred_target = r_ifid.pred_target;

endmodule : if_stage
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_stage
//  Description : Self-checking bench for if_stage. A behavioural model of
//                the fetch stage predicts the IF/ID contents each cycle and
//                pushes them to a scoreboard; they are popped and compared
//                after the clock edge. Scenario tasks add directed checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam int          ENTRIES = 16;
    localparam int          IDX     = 4;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        hit;
        logic        pt;
        logic [31:0] ptgt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, stall, br_valid, br_taken, br_pred_taken;
    logic [31:0] br_pc, br_target, br_pred_target;
    logic [31:0] imem_addr, imem_rdata;
    logic        flush, if_hit, if_pred_taken;
    logic [31:0] if_pc, if_inst, if_pred_target;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[23:0], 8'h33} ^ 32'h5A00_0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    if_stage #(.RESET_PC(32'h0000_0000), .BTB_ENTRIES(ENTRIES)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .br_valid(br_valid), .br_pc(br_pc), .br_taken(br_taken),
        .br_target(br_target), .br_pred_taken(br_pred_taken),
        .br_pred_target(br_pred_target), .flush(flush),
        .if_pc(if_pc), .if_inst(if_inst), .if_hit(if_hit),
        .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target)
    );

    // Reference model state
    logic [31:0] m_pc = 32'h0;
    logic        m_valid  [ENTRIES];
    logic [31:0] m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    logic [1:0]  m_ctr    [ENTRIES];
    exp_t        m_if;
    exp_t        sb [$];

    // One clock: check combinational outputs, advance the model, push the
    // expected IF/ID, clock the DUT and pop/compare. Starts and ends just
    // after a falling edge.
    task automatic cycle();
        int          li, ui;
        logic        hit, pt, mis, uhit;
        logic [31:0] ptgt, npc;
        exp_t        e, got;
        #1;
        li   = int'(m_pc[IDX+1:2]);
        hit  = m_valid[li] && (m_tag[li] == (m_pc >> (IDX + 2)));
        pt   = hit && m_ctr[li][1];
        ptgt = m_target[li];
        mis  = br_valid && ((br_taken != br_pred_taken) ||
                            (br_taken && (br_target != br_pred_target)));
        n_checks++;
        if (imem_addr !== m_pc) begin
            n_fail++;
            $display("FAIL imem_addr got %h want %h @%0t", imem_addr, m_pc, $time);
        end
        n_checks++;
        if (flush !== mis) begin
            n_fail++;
            $display("FAIL flush got %b want %b @%0t", flush, mis, $time);
        end
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 1'b0; m_tag[i] = '0; m_target[i] = '0; m_ctr[i] = 2'b01;
            end
            m_pc = 32'h0;
            e    = '{32'h0, NOP, 1'b0, 1'b0, 32'h0};
        end else begin
            if (mis)        npc = br_taken ? br_target : br_pc + 32'd4;
            else if (stall) npc = m_pc;
            else if (pt)    npc = ptgt;
            else            npc = m_pc + 32'd4;
            if (mis)        e = '{32'h0, NOP, 1'b0, 1'b0, 32'h0};
            else if (stall) e = m_if;
            else            e = '{m_pc, mem_word(m_pc), hit, pt, ptgt};
            if (br_valid) begin
                ui   = int'(br_pc[IDX+1:2]);
                uhit = m_valid[ui] && (m_tag[ui] == (br_pc >> (IDX + 2)));
                if (br_taken && !uhit) begin
                    m_valid[ui] = 1'b1; m_tag[ui] = br_pc >> (IDX + 2);
                    m_target[ui] = br_target; m_ctr[ui] = 2'b10;
                end else if (br_taken) begin
                    m_target[ui] = br_target;
                    if (m_ctr[ui] != 2'b11) m_ctr[ui] = m_ctr[ui] + 2'b01;
                end else if (uhit) begin
                    if (m_ctr[ui] != 2'b00) m_ctr[ui] = m_ctr[ui] - 2'b01;
                end
            end
            m_pc = npc;
        end
        m_if = e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = '{if_pc, if_inst, if_hit, if_pred_taken, if_pred_target};
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty got 0 entries want 1");
        end else begin
            e = sb.pop_front();
            if (got !== e) begin
                n_fail++;
                $display("FAIL ifid got pc=%h inst=%h hit=%b pt=%b tgt=%h want pc=%h inst=%h hit=%b pt=%b tgt=%h @%0t",
                         got.pc, got.inst, got.hit, got.pt, got.ptgt,
                         e.pc, e.inst, e.hit, e.pt, e.ptgt, $time);
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_br();
        br_valid = 1'b0; br_pc = '0; br_taken = 1'b0; br_target = '0;
        br_pred_taken = 1'b0; br_pred_target = '0;
    endtask

    // Stimulus only: an unrelated branch at 0x100 mispredicted as not-taken
    // steers the fetch PC to 'tgt'.
    task automatic redirect_to(input logic [31:0] tgt);
        br_valid = 1'b1; br_pc = 32'h100; br_taken = 1'b1; br_target = tgt;
        br_pred_taken = 1'b0; br_pred_target = '0;
        cycle();
        clear_br();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_checks++;
        if (imem_addr !== 32'h0 || if_inst !== NOP || if_pc !== 32'h0 || if_hit !== 1'b0 ||
            if_pred_taken !== 1'b0 || if_pred_target !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state got addr=%h inst=%h pc=%h hit=%b pt=%b tgt=%h want 0/00000013/0/0/0/0",
                     imem_addr, if_inst, if_pc, if_hit, if_pred_taken, if_pred_target);
        end
    endtask

    task automatic test_free_run();
        for (int i = 1; i <= 6; i++) begin
            cycle();
            n_checks++;
            if (imem_addr !== 32'(4 * i) || if_pc !== 32'(4 * (i - 1)) || if_hit !== 1'b0) begin
                n_fail++;
                $display("FAIL free_run got addr=%h if_pc=%h hit=%b want %h/%h/0",
                         imem_addr, if_pc, if_hit, 32'(4 * i), 32'(4 * (i - 1)));
            end
        end
    endtask

    task automatic test_branch_alloc();
        test_reset();
        repeat (4) cycle();
        br_valid = 1'b1; br_pc = 32'h10; br_taken = 1'b1; br_target = 32'h40;
        br_pred_taken = 1'b0; br_pred_target = '0;
        #1;
        n_checks++;
        if (flush !== 1'b1) begin
            n_fail++; $display("FAIL alloc_flush got %b want 1", flush);
        end
        cycle();
        clear_br();
        n_checks++;
        if (imem_addr !== 32'h40 || if_inst !== NOP) begin
            n_fail++; $display("FAIL alloc_redirect got addr=%h inst=%h want 40/00000013", imem_addr, if_inst);
        end
        redirect_to(32'h10);
        cycle();
        n_checks++;
        if (if_pc !== 32'h10 || if_hit !== 1'b1 || if_pred_taken !== 1'b1 || imem_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL alloc_predict got pc=%h hit=%b pt=%b addr=%h want 10/1/1/40",
                     if_pc, if_hit, if_pred_taken, imem_addr);
        end
    endtask

    task automatic test_counter_train();
        br_valid = 1'b1; br_pc = 32'h10; br_taken = 1'b0; br_target = '0;
        br_pred_taken = 1'b1; br_pred_target = 32'h40;
        #1;
        n_checks++;
        if (flush !== 1'b1) begin
            n_fail++; $display("FAIL train_flush1 got %b want 1", flush);
        end
        cycle();
        n_checks++;
        if (imem_addr !== 32'h14) begin
            n_fail++; $display("FAIL train_redirect got %h want 14", imem_addr);
        end
        br_pred_taken = 1'b0; br_pred_target = '0;
        #1;
        n_checks++;
        if (flush !== 1'b0) begin
            n_fail++; $display("FAIL train_flush2 got %b want 0", flush);
        end
        cycle();
        clear_br();
        redirect_to(32'h10);
        cycle();
        n_checks++;
        if (if_pc !== 32'h10 || if_hit !== 1'b1 || if_pred_taken !== 1'b0 || imem_addr !== 32'h14) begin
            n_fail++;
            $display("FAIL train_predict got pc=%h hit=%b pt=%b addr=%h want 10/1/0/14",
                     if_pc, if_hit, if_pred_taken, imem_addr);
        end
    endtask

    task automatic test_same_cycle();
        redirect_to(32'h10);
        // Correctly predicted taken update at index 4 while 0x10 is fetched.
        br_valid = 1'b1; br_pc = 32'h10; br_taken = 1'b1; br_target = 32'h80;
        br_pred_taken = 1'b1; br_pred_target = 32'h80;
        cycle();
        clear_br();
        n_checks++;
        if (if_pred_target !== 32'h40 || if_pred_taken !== 1'b0 || imem_addr !== 32'h14) begin
            n_fail++;
            $display("FAIL same_cycle_old got tgt=%h pt=%b addr=%h want 40/0/14",
                     if_pred_target, if_pred_taken, imem_addr);
        end
        redirect_to(32'h10);
        cycle();
        n_checks++;
        if (if_pred_target !== 32'h80 || if_hit !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle_new got tgt=%h hit=%b want 80/1", if_pred_target, if_hit);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (imem_addr !== 32'h14 || if_pc !== 32'h10 || if_pred_target !== 32'h80) begin
                n_fail++;
                $display("FAIL stall_hold got addr=%h pc=%h tgt=%h want 14/10/80",
                         imem_addr, if_pc, if_pred_target);
            end
        end
        redirect_to(32'h200);
        n_checks++;
        if (imem_addr !== 32'h200 || if_inst !== NOP || if_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL stall_redirect got addr=%h inst=%h pc=%h want 200/00000013/0",
                     imem_addr, if_inst, if_pc);
        end
        cycle();
        stall = 1'b0;
        cycle();
        n_checks++;
        if (imem_addr !== 32'h204 || if_pc !== 32'h200) begin
            n_fail++;
            $display("FAIL stall_release got addr=%h pc=%h want 204/200", imem_addr, if_pc);
        end
    endtask

    task automatic test_alias_wrap();
        redirect_to(32'h10 + 32'(4 * ENTRIES));
        cycle();
        n_checks++;
        if (if_pc !== 32'h50 || if_hit !== 1'b0 || imem_addr !== 32'h54) begin
            n_fail++;
            $display("FAIL alias got pc=%h hit=%b addr=%h want 50/0/54", if_pc, if_hit, imem_addr);
        end
        redirect_to(32'hFFFF_FFFC);
        cycle();
        n_checks++;
        if (imem_addr !== 32'h0 || if_pc !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap got addr=%h pc=%h want 0/fffffffc", imem_addr, if_pc);
        end
    endtask

    task automatic test_reset_flush();
        repeat (2) cycle();
        rst = 1'b1;
        br_valid = 1'b1; br_pc = 32'h10; br_taken = 1'b1; br_target = 32'h300;
        br_pred_taken = 1'b0; br_pred_target = '0;
        cycle();
        rst = 1'b0;
        clear_br();
        n_checks++;
        if (imem_addr !== 32'h0 || if_inst !== NOP) begin
            n_fail++;
            $display("FAIL reset_flush got addr=%h inst=%h want 0/00000013", imem_addr, if_inst);
        end
        repeat (5) cycle();
        n_checks++;
        if (if_pc !== 32'h10 || if_hit !== 1'b0 || imem_addr !== 32'h14) begin
            n_fail++;
            $display("FAIL reset_btb_clear got pc=%h hit=%b addr=%h want 10/0/14",
                     if_pc, if_hit, imem_addr);
        end
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        clear_br();
        @(negedge clk);
        test_reset();
        test_free_run();
        test_branch_alloc();
        test_counter_train();
        test_same_cycle();
        test_stall();
        test_alias_wrap();
        test_reset_flush();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule : tb_if_stage
`default_nettype wire

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of the decode stage.
- Owns the PC register and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Drives the instruction-memory address and holds the IF/ID pipeline register.
- Computes the mispredict flush from the EX-stage branch resolution; that flush feeds decode's flush input.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
BTB_ENTRIES, 16, number of BTB entries; power of two, 4..64; IDX = log2(BTB_ENTRIES)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  1  hazard-unit freeze of PC and IF/ID
imem_addr  out  32  instruction-memory address (= current PC)
imem_rdata  in  32  instruction word, combinational read of imem_addr
br_valid  in  1  EX holds a resolved conditional branch or jal this cycle
br_pc  in  32  PC of the resolved instruction
br_taken  in  1  actual outcome
br_target  in  32  actual taken target
br_pred_taken  in  1  prediction that travelled with the instruction
br_pred_target  in  32  predicted target that travelled with the instruction
flush  out  1  mispredict; kill the IF/ID and ID/EX contents
if_pc  out  32  IF/ID: PC of the held instruction
if_inst  out  32  IF/ID: instruction word
if_hit  out  1  IF/ID: BTB tag hit at fetch
if_pred_taken  out  1  IF/ID: predicted taken
if_pred_target  out  32  IF/ID: predicted target

Behaviour:
- Reset (synchronous, highest priority):
  - PC = RESET_PC.
  - if_inst = NOP (32'h0000_0013); if_pc, if_pred_target = 0; if_hit, if_pred_taken = 0.
  - All BTB valid bits cleared; all counters = 2'b01.
  - A reset asserted mid-redirect discards the pending update and the redirect.
- BTB lookup, combinational on PC:
  - idx = PC[IDX+1:2]; tag = PC[31:IDX+2].
  - hit = valid[idx] && tag match.
  - pred_taken = hit && ctr[idx][1]; pred_target = target[idx].
- mispredict (combinational, this cycle) = br_valid && (br_taken != br_pred_taken || (br_taken && br_target != br_pred_target)); flush = mispredict.
- Next-PC priority:
  1. rst -> RESET_PC.
  2. mispredict -> br_taken ? br_target : br_pc+4. This overrides stall.
  3. stall -> hold PC.
  4. pred_taken -> pred_target.
  5. otherwise PC+4.
  - All PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- IF/ID register, updated each clock:
  - mispredict -> NOP bubble: if_inst = NOP, if_pc = 0, if_hit = 0, if_pred_taken = 0, if_pred_target = 0.
  - else stall -> hold all fields.
  - else capture {PC, imem_rdata, hit, pred_taken, pred_target}.
- Latency: an instruction at PC appears on if_* one cycle after PC is presented. Redirect penalty is 2 bubbles (IF/ID killed here, ID/EX killed by decode on flush).
- BTB update, on br_valid, independent of stall, at uidx = br_pc[IDX+1:2]:
  - Taken and (tag miss or invalid): allocate valid = 1, tag, target = br_target, ctr = 2'b10.
  - Taken and hit: target = br_target; ctr saturating increment (max 2'b11).
  - Not taken and hit: ctr saturating decrement (min 2'b00).
  - Not taken and miss: no change.
- Same-cycle lookup and update to the same index: lookup sees the old contents; the write is visible next cycle.
- Misaligned PC (bits[1:0] != 0): not detected; bits[1:0] pass through to imem_addr.

Decomposition:
- Shared package pipe_pkg:
  - NOP_INST = 32'h0000_0013.
  - Counter encodings SNT = 00, WNT = 01, WT = 10, ST = 11.
  - btb_entry_t = {valid, tag, target[31:0], ctr[1:0]}; the tag width depends on IDX, so it is parameterised in the sub-module.
- One sub-module, btb_predictor: entry array, lookup port, update port, saturating-counter logic.
- if_stage keeps the PC mux, mispredict compare and IF/ID register.

Test Plan:
- Reset, then free-run with stall = 0, BTB empty -> imem_addr 0,4,8,...; if_inst lags by one cycle; if_hit = 0 throughout.
- Branch at 0x10, br_valid with br_taken = 1, br_target = 0x40, br_pred_taken = 0 -> flush = 1 that cycle; next PC = 0x40; if_inst = NOP next cycle. On the next fetch of 0x10: if_hit = 1, if_pred_taken = 1, PC after 0x10 is 0x40.
- Same branch resolved not-taken twice with correct predictions fed back -> counter 10 -> 01 -> 00. First not-taken resolution flushes and redirects to 0x14. Later fetch of 0x10 predicts not-taken, and the next PC is 0x14.
- stall held 3 cycles with no br_valid -> PC and all if_* fields frozen. Repeat with a mispredict arriving mid-stall -> redirect and NOP bubble take effect despite stall.
- Alias: entry for 0x10 allocated, then fetch 0x10 + 4*BTB_ENTRIES -> tag miss, if_hit = 0, PC+4.
- Same-cycle lookup and update at index 4 -> fetch uses the old entry; following fetch sees the new one. Separately, rst asserted during a flush cycle -> PC = RESET_PC and BTB cleared.
